// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings and helpers for the hazard control unit
package riscv_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int MD_LATENCY_DEF = 8;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       rw_m,
    input logic [4:0] rd_m,
    input logic       rw_w,
    input logic [4:0] rd_w
  );
    return (rw_m && rd_m != 5'd0 && rd_m == rs) ? FWD_MEM :
           (rw_w && rd_w != 5'd0 && rd_w == rs) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_md_timer.sv
// hazard_md_timer: stall sequencer for multi-cycle ops occupying EX
module hazard_md_timer
  import riscv_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy_stall,
  output logic done
);
  localparam int CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] LOAD = CW'(MD_LATENCY - 1);
  md_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last;
  assign last = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // start is only sampled in IDLE, so a held level cannot retrigger mid-op
  always_comb begin
    state_n = (state == MD_IDLE) ? (start ? MD_BUSY : MD_IDLE) : (last ? MD_IDLE : MD_BUSY);
    cnt_n   = (state == MD_IDLE) ? (start ? LOAD : cnt) : cnt - CW'(1);
  end
  always_comb begin
    busy_stall = !reset && ((state == MD_IDLE && start) || (state == MD_BUSY && !last));
    done       = !reset && state == MD_BUSY && last;
  end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding, load-use/control hazard and multi-cycle stall control
module hazard_ctrl_unit
  import riscv_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             MemRead_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             MulDivStart_E,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MulDivDone_E,
  output logic [CNT_W-1:0] stall_cycles
);
  logic busy, done, lw;
  hazard_md_timer #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk       (clk),
    .reset     (reset),
    .start     (MulDivStart_E),
    .busy_stall(busy),
    .done      (done)
  );
  assign lw = MemRead_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
  // a multi-cycle stall overrides load-use and redirect; a redirect cancels the load-use stall
  always_comb begin
    ForwardAE    = reset ? FWD_RF : fwd_sel(rs1_E, RegWrite_M, rd_M, RegWrite_W, rd_W);
    ForwardBE    = reset ? FWD_RF : fwd_sel(rs2_E, RegWrite_M, rd_M, RegWrite_W, rd_W);
    StallF       = !reset && (busy || (lw && !PCSrc_E));
    StallD       = StallF;
    StallE       = !reset && busy;
    FlushD       = !reset && !busy && PCSrc_E;
    FlushE       = !reset && !busy && (lw || PCSrc_E);
    FlushM       = !reset && busy;
    MulDivDone_E = !reset && done;
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cycles <= '0;
    else if (StallF && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: vector table plus multi-cycle sequences, checked via a scoreboard queue
module tb_hazard_ctrl_unit;
  typedef struct packed {
    logic rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic mr;
    logic [4:0] rd_M;
    logic rwm;
    logic [4:0] rd_W;
    logic rww, pcs, mds;
  } in_t;
  typedef struct packed {
    logic sf, sd, se, fd, fe, fm;
    logic [1:0] fa, fb;
    logic dn;
  } ctl_t;
  typedef struct {
    string name;
    in_t   in;
    ctl_t  exp;
  } vec_t;
  typedef struct {
    string name;
    ctl_t  ctl;
    logic [3:0] sc;
  } sb_t;

  logic clk = 0, reset = 1;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E, MulDivStart_E;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDivDone_E;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] stall_cycles;
  int checks = 0, errors = 0;
  logic [3:0] sc_model = 0;
  sb_t sb_q[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemRead_E(MemRead_E), .rd_M(rd_M), .rd_W(rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .PCSrc_E(PCSrc_E), .MulDivStart_E(MulDivStart_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulDivDone_E(MulDivDone_E), .stall_cycles(stall_cycles)
  );

  function automatic in_t mi(input logic rst, input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                             input logic mr, input logic [4:0] rdm, input logic rwm,
                             input logic [4:0] rdw, input logic rww, input logic pcs, input logic mds);
    return '{rst, rs1d, rs2d, rs1e, rs2e, rde, mr, rdm, rwm, rdw, rww, pcs, mds};
  endfunction

  function automatic ctl_t me(input logic sf, sd, se, fd, fe, fm,
                              input logic [1:0] fa, fb, input logic dn);
    return '{sf, sd, se, fd, fe, fm, fa, fb, dn};
  endfunction

  task automatic step(input string name, input in_t in, input ctl_t exp);
    sb_t got;
    ctl_t act;
    @(negedge clk);
    {reset, rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, rd_M, RegWrite_M, rd_W, RegWrite_W,
     PCSrc_E, MulDivStart_E} = in;
    sb_q.push_back('{name, exp, sc_model});
    sc_model = in.rst ? 4'd0 : (exp.sf && sc_model != 4'hf) ? sc_model + 4'd1 : sc_model;
    #2;
    got = sb_q.pop_front();
    act = '{StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulDivDone_E};
    checks++;
    if (act !== got.ctl) begin
      errors++;
      $display("FAIL %s ctl: got sf%b sd%b se%b fd%b fe%b fm%b fa%b fb%b dn%b want sf%b sd%b se%b fd%b fe%b fm%b fa%b fb%b dn%b",
               got.name, act.sf, act.sd, act.se, act.fd, act.fe, act.fm, act.fa, act.fb, act.dn,
               got.ctl.sf, got.ctl.sd, got.ctl.se, got.ctl.fd, got.ctl.fe, got.ctl.fm,
               got.ctl.fa, got.ctl.fb, got.ctl.dn);
    end
    checks++;
    if (stall_cycles !== got.sc) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", got.name, stall_cycles, got.sc);
    end
  endtask

  initial begin
    in_t idle_in, lw_in;
    ctl_t zero, stall, done_o, lws;
    idle_in = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw_in   = mi(0, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    zero    = me(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    stall   = me(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    done_o  = me(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    lws     = me(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    vecs[0]  = '{"reset_gate",  mi(1, 0, 7, 5, 5, 7, 1, 5, 1, 5, 1, 1, 0), zero};
    vecs[1]  = '{"fwdA_mem",    mi(0, 0, 0, 5, 3, 0, 0, 5, 1, 5, 1, 0, 0), me(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0)};
    vecs[2]  = '{"fwdA_wb",     mi(0, 0, 0, 5, 3, 0, 0, 0, 1, 5, 1, 0, 0), me(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0)};
    vecs[3]  = '{"fwdB_prio",   mi(0, 0, 0, 0, 9, 0, 0, 9, 1, 9, 1, 0, 0), me(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0)};
    vecs[4]  = '{"fwd_x0",      mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0), zero};
    vecs[5]  = '{"fwd_nowr_m",  mi(0, 0, 0, 4, 4, 0, 0, 4, 0, 4, 1, 0, 0), me(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0)};
    vecs[6]  = '{"loaduse",     lw_in, lws};
    vecs[7]  = '{"loaduse_end", mi(0, 0, 7, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0), zero};
    vecs[8]  = '{"loaduse_x0",  mi(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), zero};
    vecs[9]  = '{"pcsrc_lw",    mi(0, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0)};
    vecs[10] = '{"pcsrc",       mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), me(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0)};
    vecs[11] = '{"loaduse_rs1", mi(0, 12, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0), lws};
    {reset, rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, rd_M, RegWrite_M, rd_W, RegWrite_W,
     PCSrc_E, MulDivStart_E} = mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);
    // multi-cycle op held four cycles; a load-use in T+1 must not flush ID/EX
    idle_in.mds = 1;
    lw_in.mds = 1;
    step("md_T0", idle_in, stall);
    step("md_T1_lw", lw_in, stall);
    step("md_T2", idle_in, stall);
    step("md_T3_done", idle_in, done_o);
    idle_in.mds = 0;
    step("md_T4_idle", idle_in, zero);
    step("md_T5_idle", idle_in, zero);
    // reset one cycle into an op aborts it without a done pulse
    idle_in.mds = 1;
    step("abort_T0", idle_in, stall);
    idle_in.rst = 1;
    step("abort_T1_rst", idle_in, zero);
    idle_in = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("abort_T2", idle_in, zero);
    step("abort_T3", idle_in, zero);
    step("abort_T4", idle_in, zero);
    // continuous load-use stall drives the 4-bit counter into saturation
    lw_in.mds = 0;
    for (int k = 0; k < 19; k++) step("sat_stall", lw_in, lws);
    step("sat_hold", idle_in, zero);
    if (sc_model != 4'hf) begin
      errors++;
      $display("FAIL sat_model: got %0d want 15", sc_model);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
